// File: rtl/conv_result_streamer.sv
// Requantizes eight int32 accumulators per beat to int8, packs them into a 64-bit word and
// streams the words out through a credit-guarded FWFT FIFO with a last flag per layer.
module conv_result_streamer #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] Total_Words,
   input  logic [15:0]      Scale,
   input  logic [4:0]       Shift,
   input  logic [7:0]       Zero_Point,
   input  logic             sData_valid,
   output logic             sData_ready,
   input  logic [255:0]     sData_payload,
   output logic             mData_valid,
   input  logic             mData_ready,
   output logic [63:0]      mData_payload,
   output logic             mLast,
   output logic             LayerEnd
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0]   total_q, in_cnt_q, out_cnt_q;
   logic [15:0]        scale_q;
   logic [4:0]         shift_q;
   logic signed [7:0]  zp_q;

   logic               s1_valid_q;
   logic signed [47:0] s1_prod_q [8];
   logic signed [47:0] s1_prod_d [8];
   logic               s2_valid_q;
   logic [63:0]        s2_data_q, s2_data_d;

   logic [63:0]        fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [AW:0]        count_q;

   logic               start_ok, in_fire, out_fire;
   logic [AW+1:0]      occupancy;
   logic signed [48:0] rnd;
   logic signed [48:0] r_l [8];
   logic signed [48:0] q_l [8];
   logic signed [48:0] v_l [8];

   assign start_ok  = (state_q == StIdle) && start && (Total_Words != '0);
   assign in_fire   = sData_valid && sData_ready;
   assign out_fire  = mData_valid && mData_ready;
   // Words already in flight in S1/S2 hold a FIFO slot so the pipeline never has to stall.
   assign occupancy = (AW+2)'(count_q) + (AW+2)'(s1_valid_q) + (AW+2)'(s2_valid_q);

   assign sData_ready   = (state_q == StRun) && (in_cnt_q < total_q) &&
                          (occupancy < (AW+2)'(FIFO_DEPTH));
   assign mData_valid   = (count_q != '0);
   assign mData_payload = mData_valid ? fifo_mem[rd_ptr_q] : 64'd0;
   assign mLast         = mData_valid && (out_cnt_q == total_q - CNT_W'(1));
   assign LayerEnd      = (state_q == StDone);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_ok) state_d = StRun;
         StRun:   if (out_fire && mLast) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Scale is unsigned, so it is zero-extended before the signed multiply.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         s1_prod_d[i] = $signed(48'($signed(sData_payload[32*i +: 32]))) *
                        $signed(48'({1'b0, scale_q}));
      end
   end

   always_comb begin
      rnd = '0;
      if (shift_q != 5'd0) rnd[shift_q - 5'd1] = 1'b1;
      s2_data_d = '0;
      for (int i = 0; i < 8; i++) begin
         r_l[i] = 49'(s1_prod_q[i]) + rnd;
         q_l[i] = r_l[i] >>> shift_q;
         v_l[i] = q_l[i] + 49'(zp_q);
         if (v_l[i] > 49'sd127)       s2_data_d[8*i +: 8] = 8'h7F;
         else if (v_l[i] < -49'sd128) s2_data_d[8*i +: 8] = 8'h80;
         else                         s2_data_d[8*i +: 8] = v_l[i][7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         total_q    <= '0;
         scale_q    <= '0;
         shift_q    <= '0;
         zp_q       <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= in_fire;
         s2_valid_q <= s1_valid_q;
         if (start_ok) begin
            total_q   <= Total_Words;
            scale_q   <= Scale;
            shift_q   <= Shift;
            zp_q      <= Zero_Point;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
         end else begin
            if (in_fire)  in_cnt_q  <= in_cnt_q + CNT_W'(1);
            if (out_fire) out_cnt_q <= out_cnt_q + CNT_W'(1);
         end
         if (s2_valid_q) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (out_fire)   rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(s2_valid_q) - (AW+1)'(out_fire);
      end
   end

   always_ff @(posedge clk) begin
      s1_prod_q <= s1_prod_d;
      s2_data_q <= s2_data_d;
      if (s2_valid_q) fifo_mem[wr_ptr_q] <= s2_data_q;
   end

endmodule

// File: tb/tb_conv_result_streamer.sv
// Scoreboard bench for conv_result_streamer: stimulus queues expected words on acceptance,
// a negedge monitor pops and compares on every output handshake.
module tb_conv_result_streamer;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [31:0]  Total_Words;
   logic [15:0]  Scale;
   logic [4:0]   Shift;
   logic [7:0]   Zero_Point;
   logic         sData_valid, sData_ready;
   logic [255:0] sData_payload;
   logic         mData_valid, mData_ready;
   logic [63:0]  mData_payload;
   logic         mLast, LayerEnd;

   always #5 clk = ~clk;

   conv_result_streamer #(.FIFO_DEPTH(16), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .Total_Words(Total_Words), .Scale(Scale),
      .Shift(Shift), .Zero_Point(Zero_Point), .sData_valid(sData_valid),
      .sData_ready(sData_ready), .sData_payload(sData_payload), .mData_valid(mData_valid),
      .mData_ready(mData_ready), .mData_payload(mData_payload), .mLast(mLast),
      .LayerEnd(LayerEnd)
   );

   int          errors = 0, checks = 0;
   int          cyc = 0;
   logic [63:0] exp_q [$];
   bit          last_q [$];
   int          rx_count = 0, acc_count = 0, acc_cyc = 0;
   bit          abort = 0, le_expect = 0, hold_pend = 0;
   logic [63:0] hold_data;
   logic        hold_last;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Output monitor
   initial forever begin
      @(negedge clk);
      if (reset) begin
         hold_pend = 0;
         le_expect = 0;
      end else begin
         if (le_expect) begin
            check("layer_end", 64'(LayerEnd), 64'd1);
            le_expect = 0;
         end else if (LayerEnd) begin
            check("spurious_layer_end", 64'(LayerEnd), 64'd0);
         end
         if (hold_pend && mData_valid) begin
            check("hold_payload", mData_payload, hold_data);
            check("hold_last", 64'(mLast), 64'(hold_last));
         end
         hold_pend = mData_valid && !mData_ready;
         hold_data = mData_payload;
         hold_last = mLast;
         if (mData_valid && mData_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %h, required no word", mData_payload);
            end else begin
               logic [63:0] e;
               bit          l;
               e = exp_q.pop_front();
               l = last_q.pop_front();
               check("word_payload", mData_payload, e);
               check("word_last", 64'(mLast), 64'(l));
               if (l) le_expect = 1;
            end
            rx_count++;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input int unsigned tw, input logic [15:0] sc, input logic [4:0] sh,
                           input logic [7:0] zp);
      start = 1'b1; Total_Words = tw; Scale = sc; Shift = sh; Zero_Point = zp;
      @(posedge clk); #1;
      // Scramble config to show it was latched on start
      start = 1'b0; Total_Words = 32'd7777; Scale = 16'h5A5A; Shift = 5'd13; Zero_Point = 8'h33;
   endtask

   task automatic send_beat(input logic [255:0] pl, input logic [63:0] e, input bit l,
                            output bit ok);
      sData_payload = pl;
      sData_valid   = 1'b1;
      ok = 0;
      for (int w = 0; w < 300; w++) begin
         @(negedge clk);
         if (abort) break;
         if (sData_ready) begin
            ok = 1;
            exp_q.push_back(e);
            last_q.push_back(l);
            acc_count++;
            acc_cyc = cyc;
            break;
         end
      end
      if (ok) begin
         @(posedge clk); #1;
      end
      sData_valid = 1'b0;
      if (!ok && !abort) begin
         checks++;
         errors++;
         $display("FAIL beat_accept_timeout: got no accept, required accept");
      end
   endtask

   function automatic logic [255:0] ramp_beat(input int base);
      logic [255:0] pl;
      for (int i = 0; i < 8; i++) pl[32*i +: 32] = 32'(base + i);
      return pl;
   endfunction

   function automatic logic [63:0] ramp_exp(input int base, input int mult);
      logic [63:0] e;
      for (int i = 0; i < 8; i++) e[8*i +: 8] = 8'(mult * (base + i));
      return e;
   endfunction

   task automatic feed_ramp(input int n, input int base, input int mult);
      bit ok;
      for (int k = 0; k < n; k++) begin
         if (abort) break;
         send_beat(ramp_beat(base + k), ramp_exp(base + k, mult), k == n - 1, ok);
      end
   endtask

   task automatic wait_layer_end();
      bit found = 0;
      for (int w = 0; w < 3000; w++) begin
         if (LayerEnd) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL layer_end_timeout: got no LayerEnd, required LayerEnd");
      end
      @(posedge clk); #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_sready"}, 64'(sData_ready), 64'd0);
      check({tag, "_mvalid"}, 64'(mData_valid), 64'd0);
      check({tag, "_payload"}, mData_payload, 64'd0);
      check({tag, "_mlast"}, 64'(mLast), 64'd0);
      check({tag, "_layerend"}, 64'(LayerEnd), 64'd0);
   endtask

   logic [255:0] pl;
   bit           ok_m, seen;
   int           a, base_acc, base_rx;

   initial begin
      reset = 1'b1; start = 1'b0; Total_Words = '0; Scale = '0; Shift = '0; Zero_Point = '0;
      sData_valid = 1'b0; sData_payload = '0; mData_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_outputs_zero("reset");

      // Zero-word start is ignored
      do_start(0, 16'd1, 5'd0, 8'd0);
      check("zero_start_ready", 64'(sData_ready), 64'd0);
      @(posedge clk); #1;
      check("zero_start_ready2", 64'(sData_ready), 64'd0);

      // Passthrough with latency measurement
      do_start(1, 16'd1, 5'd0, 8'd0);
      check("ready_after_start", 64'(sData_ready), 64'd1);
      send_beat(ramp_beat(0), 64'h0706050403020100, 1, ok_m);
      a = acc_cyc;
      seen = 0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (mData_valid) begin
            check("latency", 64'(cyc - a), 64'd3);
            seen = 1;
            break;
         end
      end
      if (!seen) check("latency_valid_seen", 64'(seen), 64'd1);
      @(posedge clk); #1;
      wait_layer_end();

      // Rounding and zero point: Scale=3, Shift=2, ZP=-5
      pl = '0;
      pl[31:0]    = 32'sd5;       // 15+2>>2=4,   -1    -> FF
      pl[63:32]   = -32'sd6;      // -16>>>2=-4,  -9    -> F7
      pl[95:64]   = -32'sd7;      // -19>>>2=-5,  -10   -> F6
      pl[127:96]  = 32'sd2;       // 8>>2=2,      -3    -> FD
      pl[159:128] = 32'sd100000;  // 75000-5          -> 7F
      pl[191:160] = -32'sd100000; // -75000-5         -> 80
      pl[223:192] = 32'sd1;       // 5>>2=1,      -4    -> FC
      pl[255:224] = 32'sd43;      // 131>>2=32,   27    -> 1B
      do_start(1, 16'd3, 5'd2, 8'hFB);
      send_beat(pl, 64'h1BFC807FFDF6F7FF, 1, ok_m);
      wait_layer_end();

      // Saturation with maximum Scale
      pl = '0;
      pl[31:0]   = 32'h7FFFFFFF;
      pl[63:32]  = 32'h80000000;
      pl[127:96] = 32'hFFFFFFFF;
      do_start(1, 16'hFFFF, 5'd0, 8'd0);
      send_beat(pl, 64'h000000008000807F, 1, ok_m);
      wait_layer_end();

      // Shift=31 boundary
      pl = '0;
      pl[31:0]   = 32'h7FFFFFFF;
      pl[63:32]  = 32'h80000000;
      pl[95:64]  = 32'h40000000;
      pl[127:96] = 32'h3FFFFFFF;
      do_start(1, 16'd1, 5'd31, 8'd0);
      send_beat(pl, 64'h000000000001FF01, 1, ok_m);
      wait_layer_end();

      // Backpressure: 30 stalled cycles, then toggling ready
      mData_ready = 1'b0;
      base_acc = acc_count;
      base_rx  = rx_count;
      do_start(40, 16'd1, 5'd0, 8'd0);
      fork
         feed_ramp(40, 0, 1);
         begin
            repeat (30) @(posedge clk);
            #1;
            check("bp_accepted", 64'(acc_count - base_acc), 64'd16);
            check("bp_ready_low", 64'(sData_ready), 64'd0);
            check("bp_no_output", 64'(rx_count - base_rx), 64'd0);
            for (int w = 0; w < 600 && (rx_count - base_rx) < 40; w++) begin
               mData_ready = !mData_ready;
               @(posedge clk); #1;
            end
            mData_ready = 1'b1;
         end
      join
      check("bp_word_count", 64'(rx_count - base_rx), 64'd40);
      wait_layer_end();

      // Back-to-back layers; start during RUN is ignored
      do_start(3, 16'd1, 5'd0, 8'd0);
      feed_ramp(3, 10, 1);
      wait_layer_end();
      do_start(3, 16'd2, 5'd0, 8'd0);
      send_beat(ramp_beat(20), ramp_exp(20, 2), 0, ok_m);
      start = 1'b1; Total_Words = 32'd5; Scale = 16'd7;
      send_beat(ramp_beat(21), ramp_exp(21, 2), 0, ok_m);
      start = 1'b0;
      send_beat(ramp_beat(22), ramp_exp(22, 2), 1, ok_m);
      wait_layer_end();
      check("b2b_idle_ready", 64'(sData_ready), 64'd0);
      check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset mid-layer after 10 of 20 words
      base_rx = rx_count;
      do_start(20, 16'd1, 5'd0, 8'd0);
      fork
         feed_ramp(20, 30, 1);
         begin
            for (int w = 0; w < 500 && (rx_count - base_rx) < 10; w++) begin
               @(posedge clk); #1;
            end
            check("rst_words_before", 64'(rx_count - base_rx), 64'd10);
            mData_ready = 1'b0;
            abort = 1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check_outputs_zero("rst_mid");
            exp_q.delete();
            last_q.delete();
         end
      join
      abort = 0;
      mData_ready = 1'b1;
      base_rx = rx_count;
      do_start(3, 16'd1, 5'd0, 8'd0);
      feed_ramp(3, 90, 1);
      wait_layer_end();
      check("rst_fresh_words", 64'(rx_count - base_rx), 64'd3);

      repeat (3) @(posedge clk);
      #1;
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      check("final_idle_valid", 64'(mData_valid), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
